// File: rtl/updown_counter_pkg.sv
// Shared direction constants and terminal-count detection for updown_counter_n.
package updown_counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Out-of-range values count as terminal when counting up, so the wrap is always taken.
  function automatic logic is_terminal(input logic [31:0] q, input logic up_dn,
                                       input logic [31:0] modulus);
    if (up_dn == DIR_UP) return (q >= modulus - 32'd1);
    return (q == 32'd0);
  endfunction

endpackage

// File: rtl/updown_counter_n.sv
// Modulo-N up/down counter, clear/load/count priority, one-cycle registered q, combinational rco_n.
// No backpressure; cascade via rco_n -> ent_n. UDC_MATCH_EN adds cmp input and registered match output.
module updown_counter_n
  import updown_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             load_n,
  input  logic             sclr_n,
  input  logic             enp_n,
  input  logic             ent_n,
  input  logic             up_dn,
  output logic [WIDTH-1:0] q,
  output logic             rco_n
`ifdef UDC_MATCH_EN
  ,
  input  logic [WIDTH-1:0] cmp,
  output logic             match
`endif
);

  if (WIDTH < 2 || WIDTH > 16 || MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : g_bad_param
    $error("updown_counter_n: illegal WIDTH/MODULUS combination");
  end

  localparam logic [31:0]      MOD_U32 = 32'(MODULUS);
  localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULUS - 1);

  logic [31:0]      q_ext;
  logic             terminal;
  logic [WIDTH-1:0] q_next;

  assign q_ext    = 32'(q);
  assign terminal = is_terminal(q_ext, up_dn, MOD_U32);
  assign rco_n    = ~(~ent_n & terminal);

  always_comb begin
    q_next = q;
    if (!sclr_n)                q_next = '0;
    else if (!load_n)           q_next = d;
    else if (!enp_n && !ent_n) begin
      if (up_dn == DIR_UP)      q_next = terminal ? '0 : q + 1'b1;
      else                      q_next = terminal ? TOP_VAL : q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= q_next;
  end

`ifdef UDC_MATCH_EN
  // Compares the pre-edge count, so match lags the matching q by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) match <= 1'b0;
    else        match <= (q == cmp);
  end
`endif

endmodule
